// File: rtl/buff_rd_pkg.sv
// Shared types and constants for the ADC buffer read-side controller:
// FSM state encoding, default half depth and the tag word layout.
package buff_rd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TAG   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5
    } rd_state_e;

    localparam int HALF_DEPTH = 256;

    localparam logic [3:0] TAG_MARK     = 4'hA;
    localparam int         TAG_MARK_LSB = 12;
    localparam int         TAG_HALF_BIT = 11;
    localparam int         TAG_OVR_BIT  = 10;
    localparam int         TAG_SEQ_W    = 10;

    function automatic logic [15:0] make_tag(input logic half, input logic ovr,
                                             input logic [TAG_SEQ_W-1:0] seq);
        logic [15:0] tag;
        tag                     = 16'h0000;
        tag[TAG_MARK_LSB +: 4]  = TAG_MARK;
        tag[TAG_HALF_BIT]       = half;
        tag[TAG_OVR_BIT]        = ovr;
        tag[TAG_SEQ_W-1:0]      = seq;
        return tag;
    endfunction

endpackage

// File: rtl/buff_half_tracker.sv
// Tracks which buffer halves are full, which half the writer fills next,
// which half the reader drains next, and the sticky overrun flag.
module buff_half_tracker (
    input  logic clk,
    input  logic reset,
    input  logic sync_clr,
    input  logic write_done,
    input  logic clr_req,
    output logic half_ready,
    output logic rd_half,
    output logic overrun
);

    logic [1:0] pending_r;
    logic [1:0] pending_nxt_s;
    logic       fill_half_r;
    logic       rd_half_r;
    logic       overrun_r;

    // Next pending flags; a set from the writer wins over the reader's clear.
    always_comb begin
        pending_nxt_s = pending_r;
        if (clr_req) begin
            pending_nxt_s[rd_half_r] = 1'b0;
        end else begin
            pending_nxt_s = pending_r;
        end
        if (write_done) begin
            pending_nxt_s[fill_half_r] = 1'b1;
        end else begin
            pending_nxt_s[fill_half_r] = pending_nxt_s[fill_half_r];
        end
    end

    // Half tracking registers; sync_clr realigns everything to half 0.
    always_ff @(posedge clk) begin
        if (reset || sync_clr) begin
            pending_r   <= 2'b00;
            fill_half_r <= 1'b0;
            rd_half_r   <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            pending_r <= pending_nxt_s;
            if (write_done) begin
                fill_half_r <= ~fill_half_r;
                if (pending_r[fill_half_r]) begin
                    overrun_r <= 1'b1;
                end
            end
            if (clr_req) begin
                rd_half_r <= ~rd_half_r;
            end
        end
    end

    assign half_ready = pending_r[rd_half_r];
    assign rd_half    = rd_half_r;
    assign overrun    = overrun_r;

endmodule

// File: rtl/buff_readout_ctrl.sv
// Drains full halves of the ADC sample buffer and streams them over valid/ready.
// Optional feature macro BUFF_RD_TAG_EN: emit a tag word before each half.
module buff_readout_ctrl #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 9,
    parameter int HALF_DEPTH = buff_rd_pkg::HALF_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sync_clr,
    input  logic              write_done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              read_done,
    output logic              busy,
    output logic              overrun
);

    import buff_rd_pkg::*;

    localparam int               CNT_W    = ADDR_W - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_DEPTH - 1);
`ifdef BUFF_RD_TAG_EN
    localparam rd_state_e ST_ENTRY = ST_TAG;
`else
    localparam rd_state_e ST_ENTRY = ST_ISSUE;
`endif

    rd_state_e         state_r;
    rd_state_e         state_nxt;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              clr_req_s;
    logic              half_ready_s;
    logic              rd_half_s;
    logic              rd_en_r;
    logic [ADDR_W-1:0] rd_addr_r;
    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic              read_done_r;
    logic              busy_r;
`ifdef BUFF_RD_TAG_EN
    logic [TAG_SEQ_W-1:0] seq_r;
`endif

    buff_half_tracker u_tracker (
        .clk        (clk),
        .reset      (reset),
        .sync_clr   (sync_clr),
        .write_done (write_done && !sync_clr),
        .clr_req    (clr_req_s),
        .half_ready (half_ready_s),
        .rd_half    (rd_half_s),
        .overrun    (overrun)
    );

    // Next-state and word counter logic.
    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        clr_req_s = 1'b0;
        if (sync_clr) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (half_ready_s) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_ENTRY;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_TAG: begin
`ifdef BUFF_RD_TAG_EN
                    if (out_ready) begin
                        state_nxt = ST_ISSUE;
                    end else begin
                        state_nxt = ST_TAG;
                    end
`else
                    state_nxt = ST_IDLE;
`endif
                end
                ST_ISSUE: state_nxt = ST_WAIT;
                ST_WAIT:  state_nxt = ST_HOLD;
                ST_HOLD: begin
                    if (!out_ready) begin
                        state_nxt = ST_HOLD;
                    end else if (cnt_r == CNT_LAST) begin
                        state_nxt = ST_DONE;
                    end else begin
                        cnt_nxt   = cnt_r + CNT_W'(1);
                        state_nxt = ST_ISSUE;
                    end
                end
                ST_DONE: begin
                    clr_req_s = 1'b1;
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // State, counter and registered control outputs, decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            rd_en_r     <= 1'b0;
            rd_addr_r   <= '0;
            out_valid_r <= 1'b0;
            read_done_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            cnt_r       <= cnt_nxt;
            rd_en_r     <= (state_nxt == ST_ISSUE);
            out_valid_r <= (state_nxt == ST_HOLD) || (state_nxt == ST_TAG);
            read_done_r <= (state_nxt == ST_DONE);
            busy_r      <= (state_nxt != ST_IDLE);
            if (state_nxt == ST_ISSUE) begin
                rd_addr_r <= {rd_half_s, cnt_nxt};
            end
        end
    end

    // Output word register: buffer data one cycle after the read strobe, or the tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_r <= '0;
        end else if (state_r == ST_WAIT) begin
            out_data_r <= rd_data;
`ifdef BUFF_RD_TAG_EN
        end else if ((state_r == ST_IDLE) && (state_nxt == ST_TAG)) begin
            out_data_r <= DATA_W'(make_tag(rd_half_s, overrun, seq_r));
`endif
        end else begin
            out_data_r <= out_data_r;
        end
    end

`ifdef BUFF_RD_TAG_EN
    // Block sequence count, advanced once per drained half.
    always_ff @(posedge clk) begin
        if (reset || sync_clr) begin
            seq_r <= '0;
        end else if (state_r == ST_DONE) begin
            seq_r <= seq_r + TAG_SEQ_W'(1);
        end
    end
`endif

    assign rd_en     = rd_en_r;
    assign rd_addr   = rd_addr_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign read_done = read_done_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_buff_readout_ctrl.sv
// Self-checking bench for buff_readout_ctrl (default build, no tag words).
module tb_buff_readout_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 9;

    logic              clk = 1'b0;
    logic              reset;
    logic              sync_clr;
    logic              write_done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data = '0;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              read_done;
    logic              busy;
    logic              overrun;

    int checks  = 0;
    int errors  = 0;
    int cyc_cnt = 0;

    typedef struct {
        logic                wd;
        logic                rdy;
        logic                exp_rd_en;
        logic [ADDR_W-1:0]   exp_addr;
        logic                exp_valid;
        logic [DATA_W-1:0]   exp_data;
        logic                exp_busy;
    } vec_t;

    buff_readout_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .HALF_DEPTH(256)) dut (
        .clk        (clk),
        .reset      (reset),
        .sync_clr   (sync_clr),
        .write_done (write_done),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .read_done  (read_done),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Buffer model: every location holds its own address, one-cycle read latency.
    always @(posedge clk) if (rd_en) rd_data <= DATA_W'(rd_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_wd();
        write_done = 1'b1;
        tick();
        write_done = 1'b0;
    endtask

    task automatic pulse_sync();
        sync_clr = 1'b1;
        tick();
        sync_clr = 1'b0;
    endtask

    // Accept n words expected to be base..base+n-1, checking hold stability.
    task automatic stream(input int n, input int base, input int pct,
                          input bit need_done, input int max_cyc);
        int                got;
        int                cyc;
        int                done_cnt;
        logic              hold_pend;
        logic [DATA_W-1:0] hold_val;
        got       = 0;
        cyc       = 0;
        done_cnt  = 0;
        hold_pend = 1'b0;
        hold_val  = '0;
        while ((got < n || (need_done && done_cnt == 0)) && cyc < max_cyc) begin
            out_ready = ($urandom_range(99) < pct);
            if (read_done) done_cnt++;
            if (hold_pend) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_data", out_data, hold_val);
            end
            if (out_valid && out_ready) begin
                chk($sformatf("word%0d", base + got), out_data, base + got);
                got++;
            end
            hold_pend = out_valid && !out_ready;
            hold_val  = out_data;
            tick();
            cyc++;
        end
        chk("stream_count", got, n);
        chk("read_done_count", done_cnt, need_done ? 1 : 0);
    endtask

    task automatic wait_valid(input int max_cyc);
        int c;
        c = 0;
        while (!out_valid && c < max_cyc) begin
            tick();
            c++;
        end
        chk("wait_valid", out_valid, 1'b1);
    endtask

    initial begin
        vec_t vecs[10];
        int   t0;

        vecs[0] = '{1'b1, 1'b1, 1'b0, 9'd0, 1'b0, 16'd0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 9'd0, 1'b0, 16'd0, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 9'd0, 1'b0, 16'd0, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 9'd0, 1'b1, 16'd0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 9'd1, 1'b0, 16'd0, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 9'd0, 1'b0, 16'd0, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 9'd0, 1'b1, 16'd1, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 9'd0, 1'b1, 16'd1, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 9'd0, 1'b1, 16'd1, 1'b1};
        vecs[9] = '{1'b0, 1'b1, 1'b1, 9'd2, 1'b0, 16'd0, 1'b1};

        reset      = 1'b1;
        sync_clr   = 1'b0;
        write_done = 1'b0;
        out_ready  = 1'b0;
        repeat (3) tick();
        chk("rst_rd_en", rd_en, 1'b0);
        chk("rst_rd_addr", rd_addr, 9'd0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 16'd0);
        chk("rst_read_done", read_done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_pending", dut.u_tracker.pending_r, 2'b00);
        reset = 1'b0;
        tick();

        // Single half: cycle-exact latency and first handshakes from the table.
        for (int i = 0; i < 10; i++) begin
            write_done = vecs[i].wd;
            out_ready  = vecs[i].rdy;
            tick();
            chk($sformatf("vec%0d_rd_en", i), rd_en, vecs[i].exp_rd_en);
            if (vecs[i].exp_rd_en) chk($sformatf("vec%0d_rd_addr", i), rd_addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_data);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
        end
        write_done = 1'b0;
        stream(254, 2, 100, 1'b1, 1500);
        tick();
        chk("single_busy_after", busy, 1'b0);
        chk("single_read_done_after", read_done, 1'b0);
        chk("single_overrun", overrun, 1'b0);

        // Ping-pong: two halves 2000 cycles apart.
        pulse_sync();
        t0 = cyc_cnt;
        pulse_wd();
        stream(256, 0, 100, 1'b1, 1500);
        while (cyc_cnt - t0 < 2000) tick();
        pulse_wd();
        stream(256, 256, 100, 1'b1, 1500);
        chk("pingpong_overrun", overrun, 1'b0);

        // Back-pressure with 30% ready.
        pulse_wd();
        stream(256, 0, 30, 1'b1, 8000);
        chk("bp_overrun", overrun, 1'b0);

        // Overrun: three completions while the sink stalls.
        pulse_sync();
        out_ready = 1'b0;
        pulse_wd();
        chk("ovr_after1", overrun, 1'b0);
        pulse_wd();
        chk("ovr_after2", overrun, 1'b0);
        pulse_wd();
        chk("ovr_after3", overrun, 1'b1);
        chk("ovr_pending", dut.u_tracker.pending_r, 2'b11);
        repeat (20) tick();
        chk("ovr_pending_hold", dut.u_tracker.pending_r, 2'b11);
        chk("ovr_sticky", overrun, 1'b1);
        chk("ovr_valid_hold", out_valid, 1'b1);
        chk("ovr_data_hold", out_data, 16'd0);

        // sync_clr mid-stream after 100 words, with a coincident write_done ignored.
        stream(100, 0, 100, 1'b0, 1000);
        out_ready = 1'b0;
        wait_valid(10);
        chk("mid_data", out_data, 16'd100);
        sync_clr   = 1'b1;
        write_done = 1'b1;
        tick();
        sync_clr   = 1'b0;
        write_done = 1'b0;
        chk("clr_out_valid", out_valid, 1'b0);
        chk("clr_busy", busy, 1'b0);
        chk("clr_overrun", overrun, 1'b0);
        chk("clr_pending", dut.u_tracker.pending_r, 2'b00);
        repeat (3) tick();
        chk("clr_idle_busy", busy, 1'b0);
        pulse_wd();
        stream(256, 0, 100, 1'b1, 1500);
        chk("post_clr_overrun", overrun, 1'b0);
        tick();
        chk("post_clr_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
